// File: rtl/clk_meas_pkg.sv
// Shared types and default sizing for the clock period meter and the
// clock divider testbenches that reuse the same defaults.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_MEAS,
    S_STALL
  } meas_state_t;

  localparam int DEF_CW          = 16;
  localparam int DEF_TIMEOUT     = 50000;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Synchroniser for an asynchronous input followed by edge detection.
// sig_s is the synchronised level; rise/fall are one-cycle pulses derived
// from sig_s and its registered previous value.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic sig_in,
  output logic sig_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_s_q;

  // Shift the async input through the synchroniser chain and keep the previous level
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync_q  <= '0;
      sig_s_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_s_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_s = sync_q[SYNC_STAGES-1];
  assign rise  = sig_s & ~sig_s_q;
  assign fall  = ~sig_s & sig_s_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period (and optionally the high time) of a slow signal in
// CLK cycles, hands results out over valid/ready, flags a stalled input and
// records overruns when an unread result is replaced.
// Optional feature macro: DUTY_MEAS_EN enables high-time measurement; when
// it is undefined high_out is tied to zero and the port list is unchanged.
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int CW          = DEF_CW,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          en,
  input  logic          sig_in,
  input  logic          meas_ready,
  input  logic          clr_ovr,
  output logic [CW-1:0] period_out,
  output logic [CW-1:0] high_out,
  output logic          meas_valid,
  output logic          overrun,
  output logic          stalled
);

  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  meas_state_t   state;
  meas_state_t   state_nxt;
  logic [CW-1:0] cnt;
  logic          capture;
  logic          sig_s;
  logic          rise;
  logic          fall_unused;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK   (CLK),
    .RST   (RST),
    .sig_in(sig_in),
    .sig_s (sig_s),
    .rise  (rise),
    .fall  (fall_unused)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next state and capture strobe; a rise beats the timeout in the same cycle
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    if (!en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_ARM;
        S_ARM:   if (rise) state_nxt = S_MEAS;
        S_MEAS: begin
          if (rise)                 capture   = 1'b1;
          else if (cnt == TMO_LAST) state_nxt = S_STALL;
        end
        S_STALL: if (rise) state_nxt = S_MEAS;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Period counter: runs only while staying in MEAS, restarts on every rise
  always_ff @(posedge CLK) begin
    if (!RST)                            cnt <= '0;
    else if (state_nxt != S_MEAS || rise) cnt <= '0;
    else                                 cnt <= cnt + CW'(1);
  end

  // Stall flag mirrors residence in STALL, so the next rise clears it
  always_ff @(posedge CLK) begin
    if (!RST) stalled <= 1'b0;
    else      stalled <= (state_nxt == S_STALL);
  end

  // Result register with valid/ready handshake and sticky overrun
  always_ff @(posedge CLK) begin
    if (!RST) begin
      period_out <= '0;
      meas_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (capture) begin
        period_out <= cnt + CW'(1);
        meas_valid <= 1'b1;
      end else if (meas_valid && meas_ready) begin
        meas_valid <= 1'b0;
      end
      if (capture && meas_valid && !meas_ready) overrun <= 1'b1;
      else if (clr_ovr)                         overrun <= 1'b0;
    end
  end

`ifdef DUTY_MEAS_EN
  logic [CW-1:0] hcnt;

  // High-time counter follows the period counter but only counts high cycles
  always_ff @(posedge CLK) begin
    if (!RST)                            hcnt <= '0;
    else if (state_nxt != S_MEAS || rise) hcnt <= '0;
    else if (sig_s)                      hcnt <= hcnt + CW'(1);
  end

  // High time is captured alongside the period; the rise cycle itself is high
  always_ff @(posedge CLK) begin
    if (!RST)         high_out <= '0;
    else if (capture) high_out <= hcnt + CW'(1);
  end
`else
  logic sig_s_unused;
  assign sig_s_unused = sig_s;
  assign high_out     = '0;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter with TIMEOUT=64. A generator inside
// the tick task toggles sig_in every 'half' cycles (0 holds the level).
// Expected high_out follows DUTY_MEAS_EN.
module tb_clk_period_meter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        en = 1'b0;
  logic        sig_in = 1'b0;
  logic        meas_ready = 1'b0;
  logic        clr_ovr = 1'b0;
  logic [15:0] period_out;
  logic [15:0] high_out;
  logic        meas_valid;
  logic        overrun;
  logic        stalled;

  int n_checks = 0;
  int n_errors = 0;
  int half = 0;
  int ph = 0;
  int hits;

  always #5 CLK = ~CLK;

  clk_period_meter #(
    .CW(16),
    .TIMEOUT(64),
    .SYNC_STAGES(2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .en        (en),
    .sig_in    (sig_in),
    .meas_ready(meas_ready),
    .clr_ovr   (clr_ovr),
    .period_out(period_out),
    .high_out  (high_out),
    .meas_valid(meas_valid),
    .overrun   (overrun),
    .stalled   (stalled)
  );

  function automatic logic [31:0] hexp(int v);
`ifdef DUTY_MEAS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    if (half != 0) begin
      ph++;
      if (ph == half) begin
        sig_in = ~sig_in;
        ph = 0;
      end
    end
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_output(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(string tag, int limit);
    int k = 0;
    while (meas_valid !== 1'b1 && k < limit) begin
      tick();
      k++;
    end
    check_output(tag, 32'(meas_valid), 1);
  endtask

  initial begin
    // reset state
    ticks(3);
    check_output("rst_period", 32'(period_out), 0);
    check_output("rst_high", 32'(high_out), 0);
    check_output("rst_valid", 32'(meas_valid), 0);
    check_output("rst_overrun", 32'(overrun), 0);
    check_output("rst_stalled", 32'(stalled), 0);

    // test 1: toggle every 2 -> period 4, high 2, valid pulses every 4
    $display("[TB] test 1: period 4");
    RST = 1'b1; en = 1'b1; meas_ready = 1'b1; half = 2; ph = 0;
    wait_valid("t1_valid", 40);
    check_output("t1_period", 32'(period_out), 4);
    check_output("t1_high", 32'(high_out), hexp(2));
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (meas_valid === 1'b1) hits++;
    end
    check_output("t1_pulses", 32'(hits), 2);
    check_output("t1_overrun", 32'(overrun), 0);

    // test 2: toggle every 5 -> period 10, high 5
    $display("[TB] test 2: period 10");
    half = 5; ph = 0;
    ticks(30);
    wait_valid("t2_valid", 40);
    check_output("t2_period", 32'(period_out), 10);
    check_output("t2_high", 32'(high_out), hexp(5));

    // test 3: hold low right after that rise -> stall exactly 64 cycles later
    $display("[TB] test 3: stall");
    sig_in = 1'b0; half = 0;
    ticks(63);
    check_output("t3_stalled_63", 32'(stalled), 0);
    check_output("t3_valid_63", 32'(meas_valid), 0);
    tick();
    check_output("t3_stalled_64", 32'(stalled), 1);
    ticks(2);
    check_output("t3_stalled_hold", 32'(stalled), 1);
    check_output("t3_no_valid", 32'(meas_valid), 0);
    half = 2; ph = 0;
    ticks(4);
    check_output("t3_stalled_pre", 32'(stalled), 1);
    tick();
    check_output("t3_stalled_clr", 32'(stalled), 0);
    check_output("t3_first_rise", 32'(meas_valid), 0);
    wait_valid("t3_valid", 20);
    check_output("t3_period", 32'(period_out), 4);

    // test 4: overrun, clear, capture with simultaneous accept
    $display("[TB] test 4: overrun");
    meas_ready = 1'b0; half = 3; ph = 0;
    ticks(5);
    check_output("t4_no_ovr_yet", 32'(overrun), 0);
    check_output("t4_valid_held", 32'(meas_valid), 1);
    tick();
    check_output("t4_overrun", 32'(overrun), 1);
    check_output("t4_period", 32'(period_out), 6);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check_output("t4_ovr_clr", 32'(overrun), 0);
    check_output("t4_valid_still", 32'(meas_valid), 1);
    ticks(4);
    check_output("t4_valid_pre", 32'(meas_valid), 1);
    meas_ready = 1'b1;
    tick();
    check_output("t4_cap_acc_ovr", 32'(overrun), 0);
    check_output("t4_cap_acc_valid", 32'(meas_valid), 1);
    check_output("t4_cap_acc_period", 32'(period_out), 6);
    tick();
    check_output("t4_accepted", 32'(meas_valid), 0);

    // test 5: one-cycle reset mid-measurement
    $display("[TB] test 5: reset mid-measurement");
    RST = 1'b0;
    tick();
    RST = 1'b1;
    check_output("t5_period", 32'(period_out), 0);
    check_output("t5_high", 32'(high_out), 0);
    check_output("t5_valid", 32'(meas_valid), 0);
    check_output("t5_overrun", 32'(overrun), 0);
    check_output("t5_stalled", 32'(stalled), 0);
    ticks(5);
    check_output("t5_after_rise1", 32'(meas_valid), 0);
    ticks(4);
    check_output("t5_before_rise2", 32'(meas_valid), 0);
    tick();
    check_output("t5_rise2_valid", 32'(meas_valid), 1);
    check_output("t5_rise2_period", 32'(period_out), 6);
    check_output("t5_rise2_high", 32'(high_out), hexp(3));

    // test 6: drop en while a result is pending
    $display("[TB] test 6: enable drop");
    en = 1'b0; meas_ready = 1'b0;
    tick();
    check_output("t6_valid_held", 32'(meas_valid), 1);
    ticks(10);
    check_output("t6_valid_still", 32'(meas_valid), 1);
    check_output("t6_period_held", 32'(period_out), 6);
    check_output("t6_no_capture", 32'(overrun), 0);
    check_output("t6_no_stall", 32'(stalled), 0);
    meas_ready = 1'b1;
    tick();
    check_output("t6_accepted", 32'(meas_valid), 0);
    check_output("t6_period_kept", 32'(period_out), 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
